cc_unit: RTL and testbench

- Consumer end of the 64-bit add/sub datapath in the Execute stage of the Y86-64 pipeline.
- Takes the ALU sum, its 64-bit ripple carry vector and the ALU function code, and derives ZF/SF/OF.
- Holds those flags in the architectural condition-code register, gated by set_cc and by exceptions downstream.
- Evaluates the jXX/cmovXX condition (e_Cnd) from the registered flags for the instruction currently in Execute.

---
 rtl/cc_unit_pkg.sv | 30 +++
 rtl/cc_unit_if.sv | 28 ++
 rtl/cc_unit_cond_eval.sv | 28 ++
 rtl/cc_unit.sv | 55 +++++
 tb/tb_cc_unit.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/cc_unit_pkg.sv
// Shared encodings and reset value for the Execute-stage condition-code unit.
// Constants only; no timing or flow-control behaviour of its own.
package cc_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_XOR = 4'd3
  } alu_fun_e;

  typedef enum logic [3:0] {
    C_YES = 4'd0,
    C_LE  = 4'd1,
    C_L   = 4'd2,
    C_E   = 4'd3,
    C_NE  = 4'd4,
    C_GE  = 4'd5,
    C_G   = 4'd6
  } cond_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam logic [2:0] CC_RESET_DEF = 3'b100;

endpackage

// File: rtl/cc_unit_if.sv
// ALU-result / condition-code bundle between the Execute pipeline (master) and cc_unit (slave).
// Flags are registered (1 cycle); e_cnd is combinational; no backpressure, writes gated by set_cc.
interface cc_unit_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] alu_sum;
  logic [WIDTH-1:0] alu_carry;
  logic [3:0]       alu_fun;
  logic             set_cc;
  logic             m_exc;
  logic             w_exc;
  logic [3:0]       e_ifun;
  logic             zf;
  logic             sf;
  logic             of;
  logic             e_cnd;
  logic             cc_upd;

  modport master (
    output alu_sum, alu_carry, alu_fun, set_cc, m_exc, w_exc, e_ifun,
    input  zf, sf, of, e_cnd, cc_upd
  );

  modport slave (
    input  alu_sum, alu_carry, alu_fun, set_cc, m_exc, w_exc, e_ifun,
    output zf, sf, of, e_cnd, cc_upd
  );
endinterface

// File: rtl/cc_unit_cond_eval.sv
// jXX/cmovXX condition decode from {zf,sf,of}; purely combinational, zero latency.
// No flow control; undefined condition codes evaluate false.
module cc_unit_cond_eval
  import cc_unit_pkg::*;
(
  input  cc_t        cc_i,
  input  logic [3:0] ifun_i,
  output logic       cnd_o
);

  logic lt;

  always_comb begin
    lt    = cc_i.sf ^ cc_i.of;
    cnd_o = 1'b0;
    case (ifun_i)
      C_YES:   cnd_o = 1'b1;
      C_LE:    cnd_o = lt | cc_i.zf;
      C_L:     cnd_o = lt;
      C_E:     cnd_o = cc_i.zf;
      C_NE:    cnd_o = ~cc_i.zf;
      C_GE:    cnd_o = ~lt;
      C_G:     cnd_o = ~lt & ~cc_i.zf;
      default: cnd_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cc_unit.sv
// Y86-64 condition-code register: derives ZF/SF/OF from the ALU, flags visible 1 cycle later.
// No backpressure; stalls/bubbles arrive as set_cc=0, and M/W exceptions squash the write.
module cc_unit
  import cc_unit_pkg::*;
#(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] CC_RESET = CC_RESET_DEF
) (
  input logic       clk,
  input logic       rst_n,
  cc_unit_if.slave  bus
);

  cc_t  cc_q, cc_d;
  cc_t  cc_new;
  logic upd_q;
  logic we;
  logic is_arith;
  logic unused_carry;

  // Only the top two carries matter: overflow is carry-in xor carry-out of the sign bit.
  assign unused_carry = ^bus.alu_carry[WIDTH-3:0];

  always_comb begin
    is_arith  = (bus.alu_fun == ALU_ADD) || (bus.alu_fun == ALU_SUB);
    cc_new.zf = (bus.alu_sum == '0);
    cc_new.sf = bus.alu_sum[WIDTH-1];
    cc_new.of = is_arith & (bus.alu_carry[WIDTH-1] ^ bus.alu_carry[WIDTH-2]);
    we        = bus.set_cc & ~bus.m_exc & ~bus.w_exc;
    cc_d      = we ? cc_new : cc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q  <= cc_t'(CC_RESET);
      upd_q <= 1'b0;
    end else begin
      cc_q  <= cc_d;
      upd_q <= we;
    end
  end

  assign bus.zf     = cc_q.zf;
  assign bus.sf     = cc_q.sf;
  assign bus.of     = cc_q.of;
  assign bus.cc_upd = upd_q;

  // Condition uses the committed flags only; the OPq in Execute is never forwarded.
  cc_unit_cond_eval u_cond_eval (
    .cc_i   (cc_q),
    .ifun_i (bus.e_ifun),
    .cnd_o  (bus.e_cnd)
  );

endmodule

// File: tb/tb_cc_unit.sv
// Directed self-checking bench for cc_unit: reset, add/sub/logic flags, exception squash, cond decode.
module tb_cc_unit;

  localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] C62  = 64'h4000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cc_unit_if #(.WIDTH(64)) bus ();

  cc_unit #(.WIDTH(64), .CC_RESET(3'b100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] fun, input logic [63:0] sum, input logic [63:0] carry,
                       input logic scc, input logic mx, input logic wx);
    bus.alu_fun   = fun;
    bus.alu_sum   = sum;
    bus.alu_carry = carry;
    bus.set_cc    = scc;
    bus.m_exc     = mx;
    bus.w_exc     = wx;
  endtask

  task automatic chk_flags(input string tag, input logic z, input logic s, input logic o, input logic u);
    chk({tag, ".zf"}, 64'(bus.zf), 64'(z));
    chk({tag, ".sf"}, 64'(bus.sf), 64'(s));
    chk({tag, ".of"}, 64'(bus.of), 64'(o));
    chk({tag, ".upd"}, 64'(bus.cc_upd), 64'(u));
  endtask

  task automatic chk_cnd(input string tag, input logic [3:0] ifun, input logic exp);
    bus.e_ifun = ifun;
    #1;
    chk(tag, 64'(bus.e_cnd), 64'(exp));
  endtask

  initial begin
    logic z, s, o, e;
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    bus.e_ifun = 4'd0;
    drive(4'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset asserted between edges
    #2 rst_n = 1'b0;
    #1;
    chk_flags("rst", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_cnd("rst.e", 4'd3, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk_flags("rst_rel", 1'b1, 1'b0, 1'b0, 1'b0);

    // Add with signed overflow into the sign bit
    drive(4'd0, MSB, C62, 1'b1, 1'b0, 1'b0);
    cyc();
    chk_flags("add_ovf", 1'b0, 1'b1, 1'b1, 1'b1);
    bus.set_cc = 1'b0;
    chk_cnd("add_ovf.l", 4'd2, 1'b0);
    chk_cnd("add_ovf.le", 4'd1, 1'b0);
    chk_cnd("add_ovf.ge", 4'd5, 1'b1);
    chk_cnd("add_ovf.g", 4'd6, 1'b1);
    cyc();
    chk_flags("hold", 1'b0, 1'b1, 1'b1, 1'b0);

    // Subtract of equal operands
    drive(4'd1, 64'd0, ONES, 1'b1, 1'b0, 1'b0);
    cyc();
    chk_flags("sub_eq", 1'b1, 1'b0, 1'b0, 1'b1);
    bus.set_cc = 1'b0;
    chk_cnd("sub_eq.le", 4'd1, 1'b1);
    chk_cnd("sub_eq.ne", 4'd4, 1'b0);
    chk_cnd("sub_eq.g", 4'd6, 1'b0);
    chk_cnd("sub_eq.e", 4'd3, 1'b1);

    // Logic op: carry pattern that would look like overflow must be ignored
    drive(4'd3, ONES, C62, 1'b1, 1'b0, 1'b0);
    cyc();
    chk_flags("xor", 1'b0, 1'b1, 1'b0, 1'b1);
    chk_cnd("xor.l", 4'd2, 1'b1);
    drive(4'd2, MSB, C62, 1'b1, 1'b0, 1'b0);
    cyc();
    chk_flags("and", 1'b0, 1'b1, 1'b0, 1'b1);

    // Exceptions in M then W squash the write; next clean cycle writes
    drive(4'd0, 64'd1, 64'd0, 1'b1, 1'b1, 1'b0);
    cyc();
    chk_flags("m_exc", 1'b0, 1'b1, 1'b0, 1'b0);
    chk_cnd("m_exc.l", 4'd2, 1'b1);
    drive(4'd0, 64'd1, 64'd0, 1'b1, 1'b0, 1'b1);
    cyc();
    chk_flags("w_exc", 1'b0, 1'b1, 1'b0, 1'b0);
    drive(4'd0, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk_flags("exc_clr", 1'b0, 1'b0, 1'b0, 1'b1);
    chk_cnd("exc_clr.g", 4'd6, 1'b1);

    // Every reachable flag combination against every condition code
    for (int k = 0; k < 6; k++) begin
      z = (k / 2 == 0);
      s = (k / 2 == 2);
      o = k[0];
      drive(4'd0, (k / 2 == 0) ? 64'd0 : ((k / 2 == 1) ? 64'd5 : MSB), o ? C62 : 64'd0,
            1'b1, 1'b0, 1'b0);
      cyc();
      bus.set_cc = 1'b0;
      chk_flags($sformatf("combo%0d", k), z, s, o, 1'b1);
      for (int f = 0; f < 16; f++) begin
        case (f)
          0:       e = 1'b1;
          1:       e = (s != o) || z;
          2:       e = (s != o);
          3:       e = z;
          4:       e = !z;
          5:       e = (s == o);
          6:       e = (s == o) && !z;
          default: e = 1'b0;
        endcase
        chk_cnd($sformatf("cnd%0d_f%0d", k, f), 4'(f), e);
      end
    end

    // Reset mid-cycle overrides a pending write
    drive(4'd0, MSB, C62, 1'b1, 1'b0, 1'b0);
    cyc();
    chk_flags("pre_rst", 1'b0, 1'b1, 1'b1, 1'b1);
    drive(4'd1, 64'd7, 64'd0, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_flags("mid_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    chk_flags("rst_hold", 1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    bus.set_cc = 1'b0;
    cyc();
    chk_flags("rst_end", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
